// File: rtl/filter_peak_detector.sv
// Pulse-height analyser for the trapezoidal filter output: triggers on a threshold
// crossing, tracks the flat-top maximum and emits one record per pulse.
// state    | meaning
// IDLE     | armed, waiting for a sample above threshold
// TRACK    | inside a pulse, tracking maximum, its timestamp and width
// HOLD     | dead time after a record, input ignored
// WAIT_LOW | waiting for the input to drop before re-arming
module filter_peak_detector #(
  parameter int DATA_W    = 16,
  parameter int TS_W      = 32,
  parameter int THRESHOLD = 100,
  parameter int HOLDOFF   = 8,
  parameter int MAX_WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] input_data,
  output logic                     peak_valid,
  output logic signed [DATA_W-1:0] peak_value,
  output logic [TS_W-1:0]          peak_time,
  output logic [7:0]               peak_width,
  output logic                     pile_up,
  output logic                     busy
);
  localparam logic signed [DATA_W-1:0] TH = DATA_W'(THRESHOLD);
  localparam int HC_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [HC_W-1:0] HOLD_LOAD = HC_W'(HOLDOFF - 1);
  localparam logic [7:0] PILE_W = (MAX_WIDTH > 255) ? 8'd255 : 8'(MAX_WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_TRACK, S_HOLD, S_WAIT_LOW} state_t;

  state_t                   r_state;
  logic signed [DATA_W-1:0] r_in;
  logic signed [DATA_W-1:0] r_max;
  logic [TS_W-1:0]          r_ts_cnt;
  logic [TS_W-1:0]          r_in_ts;
  logic [TS_W-1:0]          r_max_ts;
  logic [7:0]               r_width;
  logic [HC_W-1:0]          r_hold_cnt;

  logic                     w_above;
  logic                     w_new_max;
  logic [7:0]               w_width_inc;

  assign w_above     = r_in > TH;
  assign w_new_max   = r_in > r_max;
  assign w_width_inc = (r_width == 8'hFF) ? 8'hFF : r_width + 8'd1;

  // r_in_ts is the timestamp of the sample currently held in r_in
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_in     <= '0;
      r_in_ts  <= '0;
      r_ts_cnt <= '0;
    end else begin
      r_in     <= input_data;
      r_in_ts  <= r_ts_cnt;
      r_ts_cnt <= r_ts_cnt + TS_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_max      <= '0;
      r_max_ts   <= '0;
      r_width    <= '0;
      r_hold_cnt <= '0;
      peak_valid <= 1'b0;
      peak_value <= '0;
      peak_time  <= '0;
      peak_width <= '0;
      pile_up    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      peak_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_above) begin
            r_state  <= S_TRACK;
            r_max    <= r_in;
            r_max_ts <= r_in_ts;
            r_width  <= 8'd1;
            busy     <= 1'b1;
          end
        end
        S_TRACK: begin
          if (w_above) begin
            r_width <= w_width_inc;
            if (w_new_max) begin
              r_max    <= r_in;
              r_max_ts <= r_in_ts;
            end
            // the sample reaching the width limit is part of the record
            if (w_width_inc == PILE_W) begin
              peak_valid <= 1'b1;
              peak_value <= w_new_max ? r_in : r_max;
              peak_time  <= w_new_max ? r_in_ts : r_max_ts;
              peak_width <= w_width_inc;
              pile_up    <= 1'b1;
              r_state    <= S_HOLD;
              r_hold_cnt <= HOLD_LOAD;
            end
          end else begin
            peak_valid <= 1'b1;
            peak_value <= r_max;
            peak_time  <= r_max_ts;
            peak_width <= r_width;
            pile_up    <= 1'b0;
            r_state    <= S_HOLD;
            r_hold_cnt <= HOLD_LOAD;
          end
        end
        S_HOLD: begin
          if (r_hold_cnt == '0) begin
            r_state <= S_WAIT_LOW;
          end else begin
            r_hold_cnt <= r_hold_cnt - 1'b1;
          end
        end
        S_WAIT_LOW: begin
          if (!w_above) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_filter_peak_detector.sv
// Bench for filter_peak_detector: expected records are queued as pulses are driven
// and compared when the strobe appears; a second instance uses an 8-bit timestamp.
module tb_filter_peak_detector;
  logic               clk;
  logic               reset;
  logic signed [15:0] input_data;
  logic               peak_valid;
  logic signed [15:0] peak_value;
  logic [31:0]        peak_time;
  logic [7:0]         peak_width;
  logic               pile_up;
  logic               busy;
  logic               w_valid;
  logic signed [15:0] w_value;
  logic [7:0]         w_time;
  logic [7:0]         w_width;
  logic               w_pile;
  logic               w_busy;

  filter_peak_detector dut (
    .clk(clk), .reset(reset), .input_data(input_data),
    .peak_valid(peak_valid), .peak_value(peak_value), .peak_time(peak_time),
    .peak_width(peak_width), .pile_up(pile_up), .busy(busy)
  );

  filter_peak_detector #(.TS_W(8)) u_wrap (
    .clk(clk), .reset(reset), .input_data(input_data),
    .peak_valid(w_valid), .peak_value(w_value), .peak_time(w_time),
    .peak_width(w_width), .pile_up(w_pile), .busy(w_busy)
  );

  typedef struct {
    logic signed [15:0] val;
    logic [31:0]        tm;
    logic [7:0]         width;
    logic               pile;
  } sb_t;

  typedef struct {
    int len;
    int s[10];
    int pk;
    int val;
    int width;
  } vec_t;

  sb_t         sb[$];
  sb_t         e;
  vec_t        vecs[6];
  int          n_checks = 0;
  int          n_fail = 0;
  int unsigned cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic drive(input int v, output int unsigned tag);
    @(negedge clk);
    input_data = 16'(v);
    tag = cyc;
    cyc++;
  endtask

  task automatic idle(input int v, input int n);
    int unsigned t;
    for (int i = 0; i < n; i++) drive(v, t);
  endtask

  task automatic push(input int val, input int unsigned tm, input int width, input logic pile);
    sb_t r;
    r.val   = 16'(val);
    r.tm    = tm;
    r.width = 8'(width);
    r.pile  = pile;
    sb.push_back(r);
  endtask

  always @(negedge clk) begin
    if (!reset && peak_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_strobe: got value=%0d time=%0d width=%0d, required no record",
                 peak_value, peak_time, peak_width);
      end else begin
        e = sb.pop_front();
        check("peak_value", longint'(peak_value), longint'(e.val));
        check("peak_time", longint'(peak_time), longint'(e.tm));
        check("peak_width", longint'(peak_width), longint'(e.width));
        check("pile_up", longint'(pile_up), longint'(e.pile));
        check("wrap_valid", longint'(w_valid), 1);
        check("wrap_value", longint'(w_value), longint'(e.val));
        check("wrap_time", longint'(w_time), longint'(e.tm[7:0]));
        check("wrap_width", longint'(w_width), longint'(e.width));
        check("wrap_pile", longint'(w_pile), longint'(e.pile));
      end
    end
  end

  initial begin
    int unsigned t;
    int unsigned pk_tag;
    int unsigned trig_tag;

    vecs[0] = '{9, '{0, 0, 150, 300, 450, 450, 300, 50, 0, 0}, 4, 450, 5};
    vecs[1] = '{2, '{101, 0, 0, 0, 0, 0, 0, 0, 0, 0}, 0, 101, 1};
    vecs[2] = '{4, '{-2000, -2000, 120, -2000, 0, 0, 0, 0, 0, 0}, 2, 120, 1};
    vecs[3] = '{5, '{200, 300, 300, 250, 0, 0, 0, 0, 0, 0}, 1, 300, 4};
    vecs[4] = '{6, '{101, 102, 103, 104, 105, 100, 0, 0, 0, 0}, 4, 105, 5};
    vecs[5] = '{4, '{-5, 50, 100, 0, 0, 0, 0, 0, 0, 0}, -1, 0, 0};

    reset = 1'b0;
    input_data = '0;
    #2 reset = 1'b1;
    #1;
    check("rst_peak_valid", longint'(peak_valid), 0);
    check("rst_peak_value", longint'(peak_value), 0);
    check("rst_peak_time", longint'(peak_time), 0);
    check("rst_peak_width", longint'(peak_width), 0);
    check("rst_pile_up", longint'(pile_up), 0);
    check("rst_busy", longint'(busy), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    cyc = 1;

    for (int v = 0; v < 6; v++) begin
      pk_tag = 0;
      idle(0, 3);
      for (int i = 0; i < vecs[v].len; i++) begin
        drive(vecs[v].s[i], t);
        if (i == vecs[v].pk) pk_tag = t;
      end
      if (vecs[v].width != 0) push(vecs[v].val, pk_tag, vecs[v].width, 1'b0);
      idle(0, 15);
      check($sformatf("vec%0d_drained", v), longint'(sb.size()), 0);
    end

    // isolated pulse with strobe width and busy release timing
    idle(0, 3);
    drive(150, t);
    drive(300, t);
    drive(450, pk_tag);
    drive(450, t);
    drive(300, t);
    drive(50, t);
    push(450, pk_tag, 5, 1'b0);
    check("iso_busy_track", longint'(busy), 1);
    drive(0, t);
    check("iso_no_early_strobe", longint'(peak_valid), 0);
    drive(0, t);
    check("iso_strobe", longint'(peak_valid), 1);
    drive(0, t);
    check("iso_strobe_one_cycle", longint'(peak_valid), 0);
    idle(0, 7);
    check("iso_busy_before_release", longint'(busy), 1);
    drive(0, t);
    check("iso_busy_released", longint'(busy), 0);
    idle(0, 5);

    // exactly-threshold input never triggers, then 99/101 alternation
    idle(100, 200);
    check("eq_thresh_idle", longint'(busy), 0);
    for (int i = 0; i < 48; i++) begin
      drive((i % 2) ? 101 : 99, t);
      if (i % 12 == 1) trig_tag = t;
      if (i % 12 == 2) push(101, trig_tag, 1, 1'b0);
    end
    idle(0, 15);
    check("alt_drained", longint'(sb.size()), 0);

    // pile-up on a long constant level, re-arm only after a drop
    idle(0, 3);
    for (int j = 0; j < 200; j++) begin
      drive(500, t);
      if (j == 0) pk_tag = t;
      if (j == 63) push(500, pk_tag, 64, 1'b1);
    end
    check("pile_wait_low_busy", longint'(busy), 1);
    check("pile_drained", longint'(sb.size()), 0);
    idle(0, 3);
    check("pile_rearmed", longint'(busy), 0);
    drive(500, pk_tag);
    drive(0, t);
    push(500, pk_tag, 1, 1'b0);
    idle(0, 15);
    check("rearm_drained", longint'(sb.size()), 0);

    // second pulse inside hold-off is masked, a later one is seen
    idle(0, 3);
    drive(200, pk_tag);
    drive(0, t);
    push(200, pk_tag, 1, 1'b0);
    idle(0, 3);
    idle(300, 3);
    idle(0, 7);
    drive(250, pk_tag);
    drive(0, t);
    push(250, pk_tag, 1, 1'b0);
    idle(0, 15);
    check("holdoff_drained", longint'(sb.size()), 0);

    // reset in the middle of a pulse
    idle(0, 3);
    idle(300, 5);
    #2 reset = 1'b1;
    input_data = '0;
    #1;
    check("mid_rst_peak_valid", longint'(peak_valid), 0);
    check("mid_rst_peak_value", longint'(peak_value), 0);
    check("mid_rst_peak_time", longint'(peak_time), 0);
    check("mid_rst_peak_width", longint'(peak_width), 0);
    check("mid_rst_pile_up", longint'(pile_up), 0);
    check("mid_rst_busy", longint'(busy), 0);
    check("mid_rst_wrap_busy", longint'(w_busy), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    cyc = 1;
    drive(0, t);
    drive(150, pk_tag);
    drive(0, t);
    push(150, pk_tag, 1, 1'b0);
    idle(0, 15);
    check("final_drained", longint'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
